pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Drives hold and bubble controls into every pipeline register: pc, if_id, id_exe, exe_mem, mem_wb.
- Resolves load-use hazards, EXE-resolved jumps and multi-cycle EXE operations (div), with a watchdog on the multi-cycle wait.
- Sits beside the datapath; pipeline registers consume stall_o/flush_o and treat a flush exactly like their reset load (NOP, zero operands, write disabled).

Parameters:
- MC_TIMEOUT, 64: max cycles spent in MC_WAIT before forced abort (>=2).
- CNT_W, 7: width of the watchdog counter; must hold MC_TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- ex_load_i  in  1  instruction in EXE is a load.
- ex_rd_i  in  5  EXE destination register.
- id_rs1_re_i  in  1  ID reads rs1.
- id_rs1_i  in  5  ID rs1 address.
- id_rs2_re_i  in  1  ID reads rs2.
- id_rs2_i  in  5  ID rs2 address.
- ex_jump_i  in  1  EXE resolved a taken branch/jump.
- ex_jump_addr_i  in  32  jump target.
- ex_mc_start_i  in  1  EXE begins a multi-cycle op.
- ex_mc_done_i  in  1  multi-cycle result valid this cycle.
- stall_o  out  5  hold enables: bit0 pc, bit1 if_id, bit2 id_exe, bit3 exe_mem, bit4 mem_wb.
- flush_o  out  5  bubble enables, same bit mapping.
- redirect_o  out  1  load PC with redirect_addr_o.
- redirect_addr_o  out  32  new PC.
- mc_timeout_o  out  1  one-cycle pulse on watchdog abort.
- state_o  out  2  FSM state: 0 RUN, 1 MC_WAIT, 2 ABORT.
- stall_cnt_o  out  32  perf: stall cycles.
- flush_cnt_o  out  32  perf: jump flushes.

Behaviour:
- Outputs are combinational from state + inputs; state, watchdog and counters are registered.
- rst_i=1 (sampled at clock edge):
  - Next state RUN; watchdog and counters cleared.
  - While rst_i high: stall_o=0, flush_o=5'b11111, redirect_o=0, redirect_addr_o=0, mc_timeout_o=0.
- RUN, priority jump > mc_start > load-use:
  - Jump: redirect_o=1, redirect_addr_o=ex_jump_addr_i, flush_o=5'b00110, stall_o=0. Same cycle, no extra latency. Any mc_start is ignored. Stay RUN.
  - mc_start with ex_mc_done_i=0: stall_o=5'b00111, flush_o=5'b01000. Next state MC_WAIT; watchdog<=1.
  - mc_start with done in the same cycle: no stall, stay RUN.
  - Load-use, defined as ex_load_i & ex_rd_i!=0 & ((id_rs1_re_i & id_rs1_i==ex_rd_i) | (id_rs2_re_i & id_rs2_i==ex_rd_i)): stall_o=5'b00011, flush_o=5'b00100. Exactly one bubble; stay RUN.
  - Otherwise all outputs 0.
- MC_WAIT:
  - ex_mc_done_i=1: stall_o=0, flush_o=0. Next RUN; watchdog<=0.
  - Else if watchdog==MC_TIMEOUT: stall_o=5'b00111, flush_o=5'b01000. Next ABORT.
  - Else: stall_o=5'b00111, flush_o=5'b01000; watchdog increments.
  - ex_jump_i, load-use and ex_mc_start_i are ignored in this state.
- ABORT (1 cycle): mc_timeout_o=1, flush_o=5'b01100, stall_o=5'b00011. Next RUN.
- Done arriving in the same cycle as the timeout: done wins.
- Reset mid-MC_WAIT: returns to RUN next edge, all pipeline registers flushed during reset.
- Unused state encoding 3: behave as RUN; next RUN.

Optional Feature:
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt_o increments each cycle with stall_o[0]=1 and rst_i=0.
  - flush_cnt_o increments each cycle redirect_o=1.
  - Both counters wrap at 2^32; both clear on reset.
- Not defined: both outputs tied to 0, no counter flops.

Test Plan:
- Load-use: ex_load_i=1, ex_rd_i=5, id_rs1_re_i=1, id_rs1_i=5 for one cycle -> stall_o=00011, flush_o=00100 that cycle only. Same stimulus with ex_rd_i=0 -> all zero.
- Jump plus load-use together: ex_jump_i=1, addr 0x0000_0100 -> redirect_o=1, addr 0x100, flush_o=00110, stall_o=0.
- Multi-cycle: mc_start at cycle 0, done at cycle 10 -> stall_o=00111 for cycles 0-9, cycle 10 stall_o=0, state_o 1 then 0.
- Watchdog: MC_TIMEOUT=8, mc_start, done never asserted -> ABORT entered after 8 wait cycles, mc_timeout_o single pulse, flush_o=01100, back to RUN.
- Reset in MC_WAIT: rst_i high one cycle at cycle 3 -> flush_o=11111 that cycle, state_o=0 next, watchdog restarts cleanly on next mc_start.
- PIPE_CTRL_PERF_EN: 3 load-use stalls + 2 jumps -> stall_cnt_o=3, flush_cnt_o=2; without macro both read 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Hazard/control bundle between the datapath and the pipeline scheduler.
// master: datapath side (drives hazard info, consumes controls).
// slave:  pipe_ctrl side (consumes hazard info, drives controls).
interface pipe_ctrl_if;
  logic        ex_load_i;
  logic [4:0]  ex_rd_i;
  logic        id_rs1_re_i;
  logic [4:0]  id_rs1_i;
  logic        id_rs2_re_i;
  logic [4:0]  id_rs2_i;
  logic        ex_jump_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_mc_start_i;
  logic        ex_mc_done_i;
  logic [4:0]  stall_o;
  logic [4:0]  flush_o;
  logic        redirect_o;
  logic [31:0] redirect_addr_o;
  logic        mc_timeout_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport master (
    output ex_load_i, ex_rd_i, id_rs1_re_i, id_rs1_i, id_rs2_re_i, id_rs2_i,
           ex_jump_i, ex_jump_addr_i, ex_mc_start_i, ex_mc_done_i,
    input  stall_o, flush_o, redirect_o, redirect_addr_o, mc_timeout_o,
           state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  ex_load_i, ex_rd_i, id_rs1_re_i, id_rs1_i, id_rs2_re_i, id_rs2_i,
           ex_jump_i, ex_jump_addr_i, ex_mc_start_i, ex_mc_done_i,
    output stall_o, flush_o, redirect_o, redirect_addr_o, mc_timeout_o,
           state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline (pc, if_id, id_exe,
// exe_mem, mem_wb). Handles load-use bubbles, EXE-resolved jumps and
// multi-cycle EXE ops with a watchdog that aborts a stuck wait.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic      clk_i,
  input  logic      rst_i,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    ABORT   = 2'd2,
    SPARE   = 2'd3
  } state_t;

  // Control words, bit order {mem_wb, exe_mem, id_exe, if_id, pc}
  localparam logic [4:0] STALL_MC   = 5'b00111;
  localparam logic [4:0] FLUSH_MC   = 5'b01000;
  localparam logic [4:0] STALL_LU   = 5'b00011;
  localparam logic [4:0] FLUSH_LU   = 5'b00100;
  localparam logic [4:0] FLUSH_JMP  = 5'b00110;
  localparam logic [4:0] FLUSH_ABT  = 5'b01100;
  localparam logic [4:0] FLUSH_ALL  = 5'b11111;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wd_reg, wd_next;

  logic        load_use;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        mc_timeout;

  // Load-use: EXE load writes a nonzero register that ID is about to read
  always_comb begin
    load_use = bus.ex_load_i && (bus.ex_rd_i != 5'd0) &&
               ((bus.id_rs1_re_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
                (bus.id_rs2_re_i && (bus.id_rs2_i == bus.ex_rd_i)));
  end

  // Next-state, watchdog update and control outputs; reset forces a full flush
  always_comb begin
    state_next    = state_reg;
    wd_next       = wd_reg;
    stall         = 5'd0;
    flush         = 5'd0;
    redirect      = 1'b0;
    redirect_addr = 32'd0;
    mc_timeout    = 1'b0;
    case (state_reg)
      MC_WAIT: begin
        // Done is checked first so it beats a simultaneous timeout
        if (bus.ex_mc_done_i) begin
          state_next = RUN;
          wd_next    = '0;
        end else if (wd_reg == CNT_W'(MC_TIMEOUT)) begin
          stall      = STALL_MC;
          flush      = FLUSH_MC;
          state_next = ABORT;
        end else begin
          stall      = STALL_MC;
          flush      = FLUSH_MC;
          wd_next    = wd_reg + CNT_W'(1);
        end
      end
      ABORT: begin
        // Drop the stuck op in EXE and refetch behind it
        mc_timeout = 1'b1;
        stall      = STALL_LU;
        flush      = FLUSH_ABT;
        state_next = RUN;
        wd_next    = '0;
      end
      default: begin
        // RUN and the unused encoding share this path
        state_next = RUN;
        if (bus.ex_jump_i) begin
          redirect      = 1'b1;
          redirect_addr = bus.ex_jump_addr_i;
          flush         = FLUSH_JMP;
        end else if (bus.ex_mc_start_i) begin
          if (!bus.ex_mc_done_i) begin
            stall      = STALL_MC;
            flush      = FLUSH_MC;
            state_next = MC_WAIT;
            wd_next    = CNT_W'(1);
          end
        end else if (load_use) begin
          stall = STALL_LU;
          flush = FLUSH_LU;
        end
      end
    endcase
    if (rst_i) begin
      stall         = 5'd0;
      flush         = FLUSH_ALL;
      redirect      = 1'b0;
      redirect_addr = 32'd0;
      mc_timeout    = 1'b0;
    end
  end

  // State and watchdog registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= RUN;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
    end
  end

  assign bus.stall_o         = stall;
  assign bus.flush_o         = flush;
  assign bus.redirect_o      = redirect;
  assign bus.redirect_addr_o = redirect_addr;
  assign bus.mc_timeout_o    = mc_timeout;
  assign bus.state_o         = state_reg;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Perf counters: pc-hold cycles and jump redirects, free-running wrap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      if (stall[0]) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (redirect) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_reg;
  assign bus.flush_cnt_o = flush_cnt_reg;
`else
  assign bus.stall_cnt_o = 32'd0;
  assign bus.flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (MC_TIMEOUT=8).
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MC_TIMEOUT(8), .CNT_W(7)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic idle();
    bus.ex_load_i      = 1'b0;
    bus.ex_rd_i        = 5'd0;
    bus.id_rs1_re_i    = 1'b0;
    bus.id_rs1_i       = 5'd0;
    bus.id_rs2_re_i    = 1'b0;
    bus.id_rs2_i       = 5'd0;
    bus.ex_jump_i      = 1'b0;
    bus.ex_jump_addr_i = 32'd0;
    bus.ex_mc_start_i  = 1'b0;
    bus.ex_mc_done_i   = 1'b0;
  endtask

  // Advance one edge; inputs change 1ns after it, checks 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_use_rs1(input logic [4:0] rd);
    bus.ex_load_i   = 1'b1;
    bus.ex_rd_i     = rd;
    bus.id_rs1_re_i = 1'b1;
    bus.id_rs1_i    = rd;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    settle();
    check("rst_stall", 32'(bus.stall_o), 32'h00);
    check("rst_flush", 32'(bus.flush_o), 32'h1f);
    check("rst_redir", 32'(bus.redirect_o), 32'h0);
    check("rst_addr", bus.redirect_addr_o, 32'h0);
    check("rst_tmo", 32'(bus.mc_timeout_o), 32'h0);
    tick();
    check("rst_state", 32'(bus.state_o), 32'd0);
    rst = 1'b0;
    settle();
    check("run_idle_flush", 32'(bus.flush_o), 32'h00);
    check("rst_stall_cnt", bus.stall_cnt_o, 32'd0);
    check("rst_flush_cnt", bus.flush_cnt_o, 32'd0);

    // Load-use via rs1, one cycle only
    load_use_rs1(5'd5);
    settle();
    check("lu_stall", 32'(bus.stall_o), 32'h03);
    check("lu_flush", 32'(bus.flush_o), 32'h04);
    tick();
    idle();
    settle();
    check("lu_after_stall", 32'(bus.stall_o), 32'h00);
    check("lu_after_flush", 32'(bus.flush_o), 32'h00);
    // x0 destination never hazards
    load_use_rs1(5'd0);
    settle();
    check("lu_x0_stall", 32'(bus.stall_o), 32'h00);
    check("lu_x0_flush", 32'(bus.flush_o), 32'h00);
    idle();
    // rs2 hit, then same address without read enable
    bus.ex_load_i = 1'b1; bus.ex_rd_i = 5'd7; bus.id_rs2_re_i = 1'b1; bus.id_rs2_i = 5'd7;
    settle();
    check("lu_rs2_stall", 32'(bus.stall_o), 32'h03);
    bus.id_rs2_re_i = 1'b0;
    settle();
    check("lu_rs2_noren", 32'(bus.stall_o), 32'h00);
    // Not a load: no hazard
    load_use_rs1(5'd9);
    bus.ex_load_i = 1'b0;
    settle();
    check("lu_noload", 32'(bus.stall_o), 32'h00);
    idle();

    // Jump + load-use + mc_start: jump wins
    load_use_rs1(5'd5);
    bus.ex_jump_i = 1'b1; bus.ex_jump_addr_i = 32'h0000_0100; bus.ex_mc_start_i = 1'b1;
    settle();
    check("jmp_redir", 32'(bus.redirect_o), 32'h1);
    check("jmp_addr", bus.redirect_addr_o, 32'h0000_0100);
    check("jmp_flush", 32'(bus.flush_o), 32'h06);
    check("jmp_stall", 32'(bus.stall_o), 32'h00);
    tick();
    idle();
    settle();
    check("jmp_state", 32'(bus.state_o), 32'd0);
    check("jmp_after_redir", 32'(bus.redirect_o), 32'h0);

    // mc_start with done same cycle: no stall, stay RUN
    bus.ex_mc_start_i = 1'b1; bus.ex_mc_done_i = 1'b1;
    settle();
    check("mc_fast_stall", 32'(bus.stall_o), 32'h00);
    tick();
    idle();
    settle();
    check("mc_fast_state", 32'(bus.state_o), 32'd0);

    // Multi-cycle: start at cycle 0, done at cycle 5; jump/load-use ignored while waiting
    bus.ex_mc_start_i = 1'b1;
    settle();
    check("mc0_stall", 32'(bus.stall_o), 32'h07);
    check("mc0_flush", 32'(bus.flush_o), 32'h08);
    tick();
    idle();
    for (int i = 1; i < 5; i++) begin
      load_use_rs1(5'd3);
      bus.ex_jump_i = 1'b1; bus.ex_jump_addr_i = 32'h0000_0200;
      settle();
      check($sformatf("mc%0d_state", i), 32'(bus.state_o), 32'd1);
      check($sformatf("mc%0d_stall", i), 32'(bus.stall_o), 32'h07);
      check($sformatf("mc%0d_redir", i), 32'(bus.redirect_o), 32'h0);
      tick();
      idle();
    end
    bus.ex_mc_done_i = 1'b1;
    settle();
    check("mc5_stall", 32'(bus.stall_o), 32'h00);
    check("mc5_flush", 32'(bus.flush_o), 32'h00);
    check("mc5_state", 32'(bus.state_o), 32'd1);
    tick();
    idle();
    settle();
    check("mc_done_state", 32'(bus.state_o), 32'd0);

    // Done on the same cycle the watchdog hits its limit: done wins
    bus.ex_mc_start_i = 1'b1;
    tick();
    idle();
    for (int i = 1; i < 8; i++) tick();
    bus.ex_mc_done_i = 1'b1;
    settle();
    check("race_state", 32'(bus.state_o), 32'd1);
    check("race_stall", 32'(bus.stall_o), 32'h00);
    tick();
    idle();
    settle();
    check("race_next_state", 32'(bus.state_o), 32'd0);
    check("race_tmo", 32'(bus.mc_timeout_o), 32'h0);

    // Watchdog: done never comes; 8 wait cycles then ABORT
    bus.ex_mc_start_i = 1'b1;
    tick();
    idle();
    for (int i = 1; i <= 8; i++) begin
      settle();
      check($sformatf("wd%0d_state", i), 32'(bus.state_o), 32'd1);
      check($sformatf("wd%0d_tmo", i), 32'(bus.mc_timeout_o), 32'h0);
      tick();
    end
    settle();
    check("abort_state", 32'(bus.state_o), 32'd2);
    check("abort_tmo", 32'(bus.mc_timeout_o), 32'h1);
    check("abort_flush", 32'(bus.flush_o), 32'h0c);
    check("abort_stall", 32'(bus.stall_o), 32'h03);
    tick();
    settle();
    check("abort_next_state", 32'(bus.state_o), 32'd0);
    check("abort_next_tmo", 32'(bus.mc_timeout_o), 32'h0);

    // Reset while waiting (cycle 3), then a fresh wait runs full length
    bus.ex_mc_start_i = 1'b1;
    tick();
    idle();
    tick();
    tick();
    rst = 1'b1;
    settle();
    check("rstw_state", 32'(bus.state_o), 32'd1);
    check("rstw_flush", 32'(bus.flush_o), 32'h1f);
    check("rstw_stall", 32'(bus.stall_o), 32'h00);
    tick();
    rst = 1'b0;
    settle();
    check("rstw_next_state", 32'(bus.state_o), 32'd0);
    check("rstw_next_stall", 32'(bus.stall_o), 32'h00);
    bus.ex_mc_start_i = 1'b1;
    tick();
    idle();
    for (int i = 1; i <= 8; i++) tick();
    settle();
    check("rstw_abort_state", 32'(bus.state_o), 32'd2);
    tick();

    // Perf counters: reset, 3 load-use stalls, 2 jumps
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_use_rs1(5'd4);
      tick();
      idle();
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      bus.ex_jump_i = 1'b1; bus.ex_jump_addr_i = 32'h0000_0040;
      tick();
      idle();
    end
    settle();
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_cnt", bus.stall_cnt_o, 32'd3);
    check("perf_flush_cnt", bus.flush_cnt_o, 32'd2);
`else
    check("perf_stall_cnt", bus.stall_cnt_o, 32'd0);
    check("perf_flush_cnt", bus.flush_cnt_o, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end
endmodule
